// File: rtl/mem_responder.sv
// Memory-side responder: holds the MAR and a word-addressed array.
// Serves single-word reads and writes with a fixed number of wait states.
module mem_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mar_load,
    input  logic [ADDR_WIDTH-1:0] mar_in,
    output logic [ADDR_WIDTH-1:0] mar_out,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_busy,
    output logic                  mem_ready,
    output logic                  mem_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [2:0] CNT_INIT = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   mar_q, mar_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    is_wr_q, is_wr_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    mem_we;
    logic                    req_one;
    logic                    req_both;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    assign req_one  = mem_rd ^ mem_wr;
    assign req_both = mem_rd & mem_wr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mar_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mar_q   <= mar_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_one) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        mar_d   = mar_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (mar_load) begin
                    mar_d = mar_in;
                end
                // A same-cycle MAR load is bypassed into the access.
                if (req_one) begin
                    addr_d  = mar_load ? mar_in : mar_q;
                    wdata_d = mem_wdata;
                    is_wr_d = mem_wr;
                    cnt_d   = CNT_INIT;
                end
                err_d = req_both;
            end
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (is_wr_q) begin
                        mem_we = rst_n;
                    end else begin
                        rdata_d = mem_q[addr_q];
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        mem_busy  = (state_q == S_WAIT);
        mem_ready = (state_q == S_DONE);
        mem_err   = err_q;
        mem_rdata = rdata_q;
        mar_out   = mar_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: unit 0 has two wait states, unit 1 has none.
// Directed cases then random traffic against an array-based model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic [1:0]  rst_n;
    logic [1:0]  mar_load;
    logic [7:0]  mar_in   [2];
    logic [7:0]  mar_out  [2];
    logic [1:0]  mem_rd;
    logic [1:0]  mem_wr;
    logic [15:0] mem_wdata [2];
    logic [15:0] mem_rdata [2];
    logic [1:0]  mem_busy;
    logic [1:0]  mem_ready;
    logic [1:0]  mem_err;

    logic [15:0] mm    [2][256];
    bit          vld   [2][256];
    logic [7:0]  mar_m [2];
    logic [15:0] rd_m  [2];

    int total = 0;
    int passed = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 2; i++) begin : g_dut
        mem_responder #(
            .DATA_WIDTH (16),
            .ADDR_WIDTH (8),
            .WAIT_STATES(i == 0 ? 2 : 0)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n[i]),
            .mar_load (mar_load[i]),
            .mar_in   (mar_in[i]),
            .mar_out  (mar_out[i]),
            .mem_rd   (mem_rd[i]),
            .mem_wr   (mem_wr[i]),
            .mem_wdata(mem_wdata[i]),
            .mem_rdata(mem_rdata[i]),
            .mem_busy (mem_busy[i]),
            .mem_ready(mem_ready[i]),
            .mem_err  (mem_err[i])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int u, input string tag);
        chk({tag, "_busy"}, 32'(mem_busy[u]), 32'd0);
        chk({tag, "_ready"}, 32'(mem_ready[u]), 32'd0);
        chk({tag, "_err"}, 32'(mem_err[u]), 32'd0);
        chk({tag, "_rdata"}, 32'(mem_rdata[u]), 32'(rd_m[u]));
        chk({tag, "_mar"}, 32'(mar_out[u]), 32'(mar_m[u]));
    endtask

    // One complete access; MAR loads are attempted throughout the busy
    // window and must be ignored.
    task automatic access(input int u, input bit is_wr, input logic [7:0] a,
                          input logic [15:0] d, input bit byp);
        int ws;
        ws = (u == 0) ? 2 : 0;
        if (!byp) begin
            mar_load[u] = 1'b1;
            mar_in[u]   = a;
            @(negedge clk);
            mar_load[u] = 1'b0;
            mar_m[u]    = a;
            chk("mar_load", 32'(mar_out[u]), 32'(a));
        end else begin
            mar_load[u] = 1'b1;
            mar_in[u]   = a;
            mar_m[u]    = a;
        end
        mem_rd[u]    = !is_wr;
        mem_wr[u]    = is_wr;
        mem_wdata[u] = d;
        for (int k = 0; k <= ws + 1; k++) begin
            @(negedge clk);
            if (k == 0) begin
                mem_rd[u]    = 1'b0;
                mem_wr[u]    = 1'b0;
                mem_wdata[u] = ~d;
                mar_load[u]  = 1'b1;
                mar_in[u]    = a ^ 8'h5A;
                chk("mar_accept", 32'(mar_out[u]), 32'(a));
            end
            chk("busy", 32'(mem_busy[u]), 32'(k <= ws));
            chk("ready", 32'(mem_ready[u]), 32'(k == ws + 1));
        end
        mar_load[u] = 1'b0;
        chk("mar_frozen", 32'(mar_out[u]), 32'(a));
        if (is_wr) begin
            mm[u][a]  = d;
            vld[u][a] = 1'b1;
        end else begin
            rd_m[u] = mm[u][a];
        end
        chk("rdata", 32'(mem_rdata[u]), 32'(rd_m[u]));
        @(negedge clk);
        chk("post_ready", 32'(mem_ready[u]), 32'd0);
        chk("post_busy", 32'(mem_busy[u]), 32'd0);
    endtask

    task automatic conflict(input int u);
        mem_rd[u] = 1'b1;
        mem_wr[u] = 1'b1;
        @(negedge clk);
        mem_rd[u] = 1'b0;
        mem_wr[u] = 1'b0;
        chk("err_pulse", 32'(mem_err[u]), 32'd1);
        chk("err_busy", 32'(mem_busy[u]), 32'd0);
        @(negedge clk);
        chk_idle(u, "err_after");
    endtask

    initial begin
        logic [7:0]  a;
        logic [15:0] d;
        int          op;
        rst_n    = 2'b00;
        mar_load = 2'b00;
        mem_rd   = 2'b00;
        mem_wr   = 2'b00;
        for (int u = 0; u < 2; u++) begin
            mar_in[u]    = 8'h00;
            mem_wdata[u] = 16'h0000;
            mar_m[u]     = 8'h00;
            rd_m[u]      = 16'h0000;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) chk_idle(u, "reset");
        rst_n = 2'b11;
        @(negedge clk);

        access(0, 1'b1, 8'h3C, 16'hBEEF, 1'b0);
        access(0, 1'b0, 8'h3C, 16'h0000, 1'b0);
        chk("read_beef", 32'(mem_rdata[0]), 32'h0000_BEEF);

        conflict(0);
        access(0, 1'b0, 8'h3C, 16'h0000, 1'b0);

        access(0, 1'b1, 8'h10, 16'h1010, 1'b0);
        access(0, 1'b0, 8'h10, 16'h0000, 1'b0);

        access(0, 1'b1, 8'h05, 16'hAAAA, 1'b1);
        mar_load[0]  = 1'b1;
        mar_in[0]    = 8'h05;
        mem_wr[0]    = 1'b1;
        mem_wdata[0] = 16'h1234;
        @(negedge clk);
        mar_load[0] = 1'b0;
        mem_wr[0]   = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(mem_busy[0]), 32'd1);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        mar_m[0] = 8'h00;
        rd_m[0]  = 16'h0000;
        chk_idle(0, "rst_mid");
        @(negedge clk);
        chk_idle(0, "rst_mid2");
        access(0, 1'b0, 8'h05, 16'h0000, 1'b0);
        chk("no_commit", 32'(mem_rdata[0]), 32'h0000_AAAA);

        access(1, 1'b1, 8'hFF, 16'h0F0F, 1'b1);
        access(1, 1'b0, 8'hFF, 16'h0000, 1'b0);
        chk("read_ff", 32'(mem_rdata[1]), 32'h0000_0F0F);
        conflict(1);

        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 30; n++) begin
                op = $urandom_range(0, 9);
                a  = 8'($urandom_range(0, 255));
                d  = 16'($urandom);
                if (op == 0) begin
                    conflict(u);
                end else if (op < 5 || !vld[u][a]) begin
                    access(u, 1'b1, a, d, 1'($urandom_range(0, 1)));
                end else begin
                    access(u, 1'b0, a, d, 1'($urandom_range(0, 1)));
                end
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
